cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 8: number of functional-unit requesters (ALU0-2, MUL, DIV, LOAD, STORE, BRANCH).
REQ-002 Parameter NUM_LANES, default 5: number of common-data-bus lanes driven toward the ROB and reservation stations.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset (asserted when 0).
REQ-005 Port flush  input  1: squash; discards this cycle's grants and clears lane outputs.
REQ-006 Port req_valid  input  NUM_REQ: requester i holds a completed result.
REQ-007 Port req_dest_rob  input  NUM_REQ x 5: ROB index of requester i's result.
REQ-008 Port req_value  input  NUM_REQ x 32: result value of requester i.
REQ-009 Port req_ready  output  NUM_REQ: combinational grant; result i is accepted this cycle.
REQ-010 Port bus  output  NUM_LANES x rv_structs::data_bus: registered lanes {valid, dest_rob, value}.

Function
REQ-011 Handshake SHALL be valid/ready: transfer on req_valid[i] & req_ready[i] at rising edge; requester holds valid and payload stable until granted.
REQ-012 req_ready[i] SHALL never be 1 while req_valid[i] is 0.
REQ-013 Arbitration SHALL be round-robin: scan requesters circularly from rr_ptr (3 bits), grant first min(NUM_LANES, popcount(req_valid)) valid requesters.
REQ-014 k-th granted requester in scan order SHALL occupy lane k; lanes k >= number of grants idle.
REQ-015 Latency SHALL be one cycle: grant in cycle N -> bus[k].valid=1 with granted dest_rob/value in cycle N+1.
REQ-016 Idle lanes SHALL drive valid=0; their dest_rob/value hold previous values (don't-care).
REQ-017 If any grant, rr_ptr SHALL update to (index of last granted requester + 1) mod NUM_REQ; no grants -> rr_ptr unchanged.
REQ-018 Wrap-around: scan from rr_ptr=6 with all valid SHALL grant 6,7,0,1,2 in lanes 0-4.
REQ-019 <= NUM_LANES valid requesters SHALL all be granted same cycle, regardless of rr_ptr.
REQ-020 flush=1 SHALL force req_ready=0 that cycle, all bus[k].valid=0 next cycle; rr_ptr unchanged.
REQ-021 No starvation: continuously valid requester SHALL be granted within ceil(NUM_REQ/NUM_LANES)=2 cycles.
REQ-022 Duplicate dest_rob across requesters SHALL not be checked; both forwarded on separate lanes.
REQ-023 No backpressure from ROB; every lane valid is consumed the cycle it is presented.

Reset
REQ-024 rst=0 SHALL immediately (asynchronously) clear all bus[k].valid, dest_rob, value to 0 and rr_ptr to 0.
REQ-025 req_ready SHALL be 0 while rst=0, regardless of req_valid.
REQ-026 Reset deasserted mid-operation: in-flight lane contents discarded; ungranted requesters re-arbitrate from rr_ptr=0 on first cycle after release.

Verification
REQ-027 Reset, then req_valid=8'b0000_0001, dest_rob=3, value=156 -> req_ready[0]=1 same cycle; next cycle bus[0]={1,3,156}, bus[1..4].valid=0, rr_ptr=1.
REQ-028 rr_ptr=0, all 8 valid, requester i value=200+i, dest_rob=i -> cycle N grants 0-4 (lanes 0-4, values 200-204), rr_ptr=5; cycle N+1 grants 5,6,7 on lanes 0-2 (values 205-207), lanes 3-4 invalid, rr_ptr=0.
REQ-029 rr_ptr=6, all 8 valid -> grants 6,7,0,1,2 on lanes 0-4; rr_ptr=3; requesters 3,4,5 granted next cycle.
REQ-030 Valid requesters {1,4,7}, values 201/204/207 -> all granted one cycle; lanes 0-2 carry 201,204,207; rr_ptr=0.
REQ-031 Grant cycle with flush=1, all valid -> req_ready=0x00, next cycle all lanes invalid, rr_ptr unchanged; flush=0 following cycle -> normal grants resume from same rr_ptr.
REQ-032 rst driven 0 between clock edges while lanes valid -> all bus valid drop to 0 before next edge; req_ready=0 until release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin selection of up to NUM_LANES completed
// functional-unit results per cycle, forwarded on registered CDB lanes.

package rv_structs;
  typedef struct packed {
    logic        valid;
    logic [4:0]  dest_rob;
    logic [31:0] value;
  } data_bus;
endpackage

module cdb_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_LANES = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][4:0]            req_dest_rob,
  input  logic [NUM_REQ-1:0][31:0]           req_value,
  output logic [NUM_REQ-1:0]                 req_ready,
  output rv_structs::data_bus [NUM_LANES-1:0] bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_LANES + 1);
  localparam int LIX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [PTR_W-1:0]                  r_rr_ptr;
  rv_structs::data_bus [NUM_LANES-1:0] r_bus;

  logic [PTR_W-1:0]                  w_next_ptr;
  logic [PTR_W-1:0]                  w_idx;
  logic [PTR_W:0]                    w_scan;
  logic [CNT_W-1:0]                  w_cnt;
  logic [NUM_REQ-1:0]                w_grant;
  logic [NUM_LANES-1:0]              w_lane_vld;
  logic [NUM_LANES-1:0][PTR_W-1:0]   w_lane_idx;
  logic                              w_arb_en;

  // Grants are suppressed while in reset or squashing, which also freezes rr_ptr.
  assign w_arb_en  = rst & ~flush;
  assign req_ready = w_grant;
  assign bus       = r_bus;

  // Circular scan from rr_ptr; the k-th grant in scan order is steered to lane k.
  always_comb begin
    w_grant    = '0;
    w_lane_vld = '0;
    w_lane_idx = '0;
    w_next_ptr = r_rr_ptr;
    w_cnt      = '0;
    w_scan     = '0;
    w_idx      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(j);
      if (w_scan >= (PTR_W+1)'(NUM_REQ)) begin
        w_scan = w_scan - (PTR_W+1)'(NUM_REQ);
      end else begin
        w_scan = w_scan;
      end
      w_idx = w_scan[PTR_W-1:0];
      if (w_arb_en && req_valid[w_idx] && (w_cnt < CNT_W'(NUM_LANES))) begin
        w_grant[w_idx]                = 1'b1;
        w_lane_vld[w_cnt[LIX_W-1:0]] = 1'b1;
        w_lane_idx[w_cnt[LIX_W-1:0]] = w_idx;
        w_cnt                         = w_cnt + CNT_W'(1);
        if (w_idx == PTR_W'(NUM_REQ - 1)) begin
          w_next_ptr = '0;
        end else begin
          w_next_ptr = w_idx + PTR_W'(1);
        end
      end else begin
        w_cnt = w_cnt;
      end
    end
  end

  // Lane registers and round-robin pointer; idle lanes keep their stale payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      r_bus    <= '0;
    end else begin
      r_rr_ptr <= w_next_ptr;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_bus[k].valid <= w_lane_vld[k];
        if (w_lane_vld[k]) begin
          r_bus[k].dest_rob <= req_dest_rob[w_lane_idx[k]];
          r_bus[k].value    <= req_value[w_lane_idx[k]];
        end
      end
    end
  end

endmodule
